// File: rtl/core_mem_mp_if.sv
// rtl/core_mem_mp_if.sv - Multi-port membus bundle between bus masters and core_mem_mp
interface core_mem_mp_if #(
  parameter int PORTS = 4
);
  logic [PORTS-1:0]    rq_cyc;
  logic [PORTS-1:0]    rd_rq;
  logic [PORTS-1:0]    wr_rq;
  logic [PORTS*15-1:0] ma;
  logic [PORTS*4-1:0]  sel;
  logic [PORTS-1:0]    fmc_select;
  logic [PORTS*36-1:0] mb_in;
  logic [PORTS-1:0]    wr_rs;
  logic [PORTS-1:0]    addr_ack;
  logic [PORTS-1:0]    rd_rs;
  logic [PORTS*36-1:0] mb_out;

  modport master (
    output rq_cyc, rd_rq, wr_rq, ma, sel, fmc_select, mb_in, wr_rs,
    input  addr_ack, rd_rs, mb_out
  );

  modport slave (
    input  rq_cyc, rd_rq, wr_rq, ma, sel, fmc_select, mb_in, wr_rs,
    output addr_ack, rd_rs, mb_out
  );
endinterface

// File: rtl/core_mem_mp.sv
// rtl/core_mem_mp.sv - Multi-port 36-bit core memory answering membus read/write/RMW cycles
// Define COREMEM_RR_ARB_EN for round-robin arbitration; otherwise the lowest port number wins.
module core_mem_mp #(
  parameter int         PORTS  = 4,
  parameter int         AW     = 14,
  parameter logic [3:0] SEL    = 4'd0,
  parameter int         RD_DLY = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         power,
  core_mem_mp_if.slave membus,
  output logic         busy
);
  localparam int CW = $clog2(RD_DLY + 1);
  localparam int GW = (PORTS > 1) ? $clog2(PORTS) : 1;

  typedef enum logic [2:0] {IDLE, ACK, RD, WWAIT, WR, REL} state_t;

  state_t              state_q, state_n;
  logic [GW-1:0]       grant_q, req_idx;
  logic [AW-1:0]       addr_q;
  logic                rd_q, wr_q;
  logic [CW-1:0]       cnt_q, cnt_n;
  logic [35:0]         wdata_q, rdata_q;
  logic [PORTS-1:0]    req, ack_q, ack_n, rs_q, rs_n, onehot;
  logic [PORTS*36-1:0] mb_out_w;
  logic                req_any, take, load_wd, rd_fire, wr_fire;
  int                  k;

  logic [35:0] mem [2**AW];

  // Address bits above AW disqualify a port rather than aliasing into the array.
  always_comb begin
    req = '0;
    for (int p = 0; p < PORTS; p++) begin
      req[p] = membus.rq_cyc[p] & ~membus.fmc_select[p]
             & (membus.sel[p*4 +: 4] == SEL)
             & (membus.rd_rq[p] | membus.wr_rq[p])
             & ~|(membus.ma[p*15 +: 15] >> AW)
             & power;
    end
  end

  // Scan from lowest to highest priority so the last hit is the winner.
  always_comb begin
    req_any = |req;
    req_idx = '0;
    k       = 0;
    for (int i = PORTS - 1; i >= 0; i--) begin
`ifdef COREMEM_RR_ARB_EN
      k = (int'(grant_q) + 1 + i) % PORTS;
`else
      k = i;
`endif
      if (req[k[GW-1:0]]) req_idx = k[GW-1:0];
    end
  end

  always_comb begin
    onehot          = '0;
    onehot[grant_q] = 1'b1;
  end

  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    ack_n   = '0;
    rs_n    = '0;
    take    = 1'b0;
    load_wd = 1'b0;
    rd_fire = 1'b0;
    wr_fire = 1'b0;
    if (!power) begin
      state_n = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_any) begin
            take    = 1'b1;
            state_n = ACK;
          end
        end
        ACK: begin
          ack_n   = onehot;
          cnt_n   = CW'(RD_DLY);
          state_n = RD;
        end
        RD: begin
          if (cnt_q == '0) begin
            rd_fire = rd_q;
            if (rd_q) rs_n = onehot;
            state_n = wr_q ? WWAIT : REL;
          end else begin
            cnt_n = cnt_q - CW'(1);
          end
        end
        WWAIT: begin
          if (membus.wr_rs[grant_q]) begin
            load_wd = 1'b1;
            state_n = WR;
          end
        end
        WR: begin
          wr_fire = 1'b1;
          state_n = REL;
        end
        REL: begin
          if (!membus.rq_cyc[grant_q]) state_n = IDLE;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      addr_q  <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      cnt_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      ack_q   <= '0;
      rs_q    <= '0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      ack_q   <= ack_n;
      rs_q    <= rs_n;
      if (take) begin
        grant_q <= req_idx;
        addr_q  <= membus.ma[int'(req_idx)*15 +: AW];
        rd_q    <= membus.rd_rq[req_idx];
        wr_q    <= membus.wr_rq[req_idx];
      end
      if (load_wd) wdata_q <= membus.mb_in[int'(grant_q)*36 +: 36];
      if (rd_fire) rdata_q <= mem[addr_q];
    end
  end

  // Array is deliberately outside the reset domain so contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_fire) mem[addr_q] <= wdata_q;
  end

  always_comb begin
    mb_out_w = '0;
    for (int p = 0; p < PORTS; p++) begin
      if (rs_q[p]) mb_out_w[p*36 +: 36] = rdata_q;
    end
  end

  assign membus.addr_ack = ack_q;
  assign membus.rd_rs    = rs_q;
  assign membus.mb_out   = mb_out_w;
  assign busy            = (state_q != IDLE);

endmodule

// File: tb/tb_core_mem_mp.sv
// tb/tb_core_mem_mp.sv - Randomized self-checking bench for core_mem_mp against a sparse memory model
`timescale 1ns/1ps
module tb_core_mem_mp;
  localparam int         PORTS  = 4;
  localparam int         AW     = 14;
  localparam int         RD_DLY = 4;
  localparam logic [3:0] SEL_V  = 4'd3;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  logic power = 1'b0;
  logic busy;

  core_mem_mp_if #(.PORTS(PORTS)) bus ();

  core_mem_mp #(.PORTS(PORTS), .AW(AW), .SEL(SEL_V), .RD_DLY(RD_DLY)) dut (
    .clk    (clk),
    .reset  (reset),
    .power  (power),
    .membus (bus.slave),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  int          n_vec  = 0;
  int          n_miss = 0;
  logic [35:0] mdl [int];

  task automatic chk(input string tag, input logic [159:0] got, input logic [159:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int model_arb(input logic [3:0] rq, input int last);
`ifdef COREMEM_RR_ARB_EN
    for (int i = 1; i <= 4; i++) if (rq[(last + i) % 4]) return (last + i) % 4;
`else
    for (int i = 0; i < 4; i++) if (rq[i]) return i;
`endif
    return -1;
  endfunction

  task automatic idle_all();
    bus.rq_cyc     = '0;
    bus.rd_rq      = '0;
    bus.wr_rq      = '0;
    bus.ma         = '0;
    bus.sel        = '0;
    bus.fmc_select = '0;
    bus.mb_in      = '0;
    bus.wr_rs      = '0;
  endtask

  task automatic wait_ack(input int p, output bit got);
    int n;
    got = 1'b0;
    n   = 0;
    while (!got && n < 10) begin
      @(negedge clk);
      got = bus.addr_ack[p];
      n++;
    end
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk(tag, busy, 1'b0);
  endtask

  task automatic xact(input int p, input int a, input bit rd, input bit wr,
                      input logic [35:0] wd, input int wdly);
    logic [PORTS*36-1:0] emb;
    bit got, early;
    bus.ma[p*15 +: 15] = a[14:0];
    bus.sel[p*4 +: 4]  = SEL_V;
    bus.rd_rq[p]       = rd;
    bus.wr_rq[p]       = wr;
    bus.rq_cyc[p]      = 1'b1;
    wait_ack(p, got);
    chk("addr_ack", got, 1'b1);
    if (got) begin
      early = 1'b0;
      for (int i = 1; i <= RD_DLY; i++) begin
        @(negedge clk);
        if (i == 1) chk("ack_pulse", bus.addr_ack, '0);
        early |= |bus.rd_rs;
      end
      chk("rs_early", early, 1'b0);
      @(negedge clk);
      emb = '0;
      if (rd && mdl.exists(a)) emb[p*36 +: 36] = mdl[a];
      chk("rd_rs", bus.rd_rs, rd ? (4'b0001 << p) : 4'b0000);
      if (!rd || mdl.exists(a)) chk("mb_out", bus.mb_out, emb);
      @(negedge clk);
      chk("rs_pulse", {bus.rd_rs, bus.mb_out}, '0);
      if (wr) begin
        repeat (wdly) @(negedge clk);
        bus.mb_in[p*36 +: 36] = wd;
        bus.wr_rs[p]          = 1'b1;
        @(negedge clk);
        bus.wr_rs[p] = 1'b0;
        mdl[a]       = wd;
      end
    end
    bus.rq_cyc[p] = 1'b0;
    bus.rd_rq[p]  = 1'b0;
    bus.wr_rq[p]  = 1'b0;
    wait_idle("release");
  endtask

  task automatic no_ack(input string tag);
    bit seen;
    seen          = 1'b0;
    bus.rq_cyc[1] = 1'b1;
    bus.rd_rq[1]  = 1'b1;
    repeat (6) begin
      @(negedge clk);
      seen |= (|bus.addr_ack) | busy;
    end
    chk(tag, seen, 1'b0);
    idle_all();
    @(negedge clk);
  endtask

  // Reaches WWAIT, offers write data, then aborts via reset or power loss.
  task automatic abort_write(input int p, input int a, input logic [35:0] wd, input bit use_reset);
    bit got;
    bus.ma[p*15 +: 15] = a[14:0];
    bus.sel[p*4 +: 4]  = SEL_V;
    bus.wr_rq[p]       = 1'b1;
    bus.rq_cyc[p]      = 1'b1;
    wait_ack(p, got);
    chk("abort_ack", got, 1'b1);
    repeat (RD_DLY + 2) @(negedge clk);
    chk("abort_busy", busy, 1'b1);
    bus.mb_in[p*36 +: 36] = wd;
    bus.wr_rs[p]          = 1'b1;
    if (use_reset) begin
      #2 reset = 1'b0;
      #1 chk("reset_outs", {busy, bus.addr_ack, bus.rd_rs, bus.mb_out}, '0);
      @(negedge clk);
      idle_all();
      reset = 1'b1;
    end else begin
      power = 1'b0;
      @(negedge clk);
      chk("power_outs", {busy, bus.addr_ack, bus.rd_rs, bus.mb_out}, '0);
      idle_all();
      power = 1'b1;
    end
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not reach summary");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [35:0] d;
    int          pool [8];
    int          a, p, op, exp_g, last_g, grants;

    idle_all();
    power = 1'b1;
    #1 chk("reset_state", {busy, bus.addr_ack, bus.rd_rs, bus.mb_out}, '0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    xact(2, 'o42, 1'b0, 1'b1, 36'o334000_000000, 0);
    xact(0, 'o42, 1'b1, 1'b0, '0, 0);

    xact(1, 'o100, 1'b0, 1'b1, 36'o173040_000000, 10);
    xact(3, 'o100, 1'b1, 1'b0, '0, 0);

    xact(0, 'o43, 1'b0, 1'b1, 36'd0, 0);
    xact(0, 'o43, 1'b1, 1'b1, 36'o777777_777777, 2);
    xact(1, 'o43, 1'b1, 1'b0, '0, 0);

    idle_all();
    bus.ma[15 +: 15] = 15'o42;
    bus.sel[4 +: 4]  = SEL_V;
    bus.fmc_select[1] = 1'b1;
    no_ack("fmc_select");
    bus.ma[15 +: 15] = 15'o42;
    bus.sel[4 +: 4]  = SEL_V ^ 4'd1;
    no_ack("sel_mismatch");
    bus.ma[15 +: 15] = 15'h4000 | 15'o42;
    bus.sel[4 +: 4]  = SEL_V;
    no_ack("ma_high_bit");
    bus.ma[15 +: 15] = 15'o42;
    bus.sel[4 +: 4]  = SEL_V;
    power = 1'b0;
    no_ack("power_off");
    power = 1'b1;

    xact(0, 'o200, 1'b0, 1'b1, 36'o5, 1);
    abort_write(1, 'o200, 36'o7070, 1'b1);
    xact(2, 'o200, 1'b1, 1'b0, '0, 0);
    abort_write(3, 'o200, 36'o1234, 1'b0);
    xact(0, 'o200, 1'b1, 1'b0, '0, 0);

    for (int i = 0; i < 8; i++) begin
      pool[i]  = int'($urandom_range(2**AW - 1));
      d[35:32] = 4'($urandom);
      d[31:0]  = $urandom;
      xact(int'($urandom_range(3)), pool[i], 1'b0, 1'b1, d, int'($urandom_range(4)));
    end
    repeat (40) begin
      a        = pool[$urandom_range(7)];
      p        = int'($urandom_range(3));
      op       = int'($urandom_range(2));
      d[35:32] = 4'($urandom);
      d[31:0]  = $urandom;
      case (op)
        0:       xact(p, a, 1'b1, 1'b0, '0, 0);
        1:       xact(p, a, 1'b0, 1'b1, d, int'($urandom_range(5)));
        default: xact(p, a, 1'b1, 1'b1, d, int'($urandom_range(5)));
      endcase
    end

    reset = 1'b0;
    idle_all();
    @(negedge clk);
    reset = 1'b1;
    bus.ma[0 +: 15]  = 15'o42;
    bus.ma[30 +: 15] = 15'o100;
    bus.sel          = {4{SEL_V}};
    bus.rd_rq[0]     = 1'b1;
    bus.rd_rq[2]     = 1'b1;
    bus.rq_cyc[0]    = 1'b1;
    bus.rq_cyc[2]    = 1'b1;
    last_g = 0;
    grants = 0;
    for (int c = 0; c < 300 && grants < 6; c++) begin
      @(negedge clk);
      for (int q = 0; q < 4; q += 2) begin
        if (!bus.rq_cyc[q]) bus.rq_cyc[q] = 1'b1;
        else if (bus.rd_rs[q]) bus.rq_cyc[q] = 1'b0;
      end
      if (bus.addr_ack != '0) begin
        exp_g = model_arb(4'b0101, last_g);
        chk("arb_grant", bus.addr_ack, 4'b0001 << exp_g);
        last_g = exp_g;
        grants++;
      end
    end
    chk("arb_count", grants, 6);
    idle_all();
    wait_idle("arb_release");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule

// File: doc/core_mem_mp.md
CORE_MEM_MP -- requirements
Module: core_mem_mp

Interface
Parameters (name, default, meaning):
REQ-001 PORTS, 4: number of membus ports, legal range 1..4.
REQ-002 AW, 14: word address width; depth is 2**AW words, legal range 10..15.
REQ-003 SEL, 0: 4-bit module select value this memory answers to.
REQ-004 RD_DLY, 4: clocks from address acknowledge to read restart, legal range >= 1.

Ports (name, direction, width, meaning):
REQ-005 clk  in  1  single system clock; all state changes on its rising edge.
REQ-006 reset  in  1  asynchronous, active-low reset.
REQ-007 power  in  1  memory powered; low forces IDLE and blocks new cycles.
REQ-008 membus_rq_cyc  in  PORTS  per-port cycle request.
REQ-009 membus_rd_rq  in  PORTS  per-port read request.
REQ-010 membus_wr_rq  in  PORTS  per-port write request.
REQ-011 membus_ma  in  PORTS*15  per-port word address, bits 21:35; port p in slice p.
REQ-012 membus_sel  in  PORTS*4  per-port module select, bits 18:21.
REQ-013 membus_fmc_select  in  PORTS  per-port fast-memory select; high means the cycle is not for this block.
REQ-014 membus_mb_in  in  PORTS*36  per-port write data.
REQ-015 membus_wr_rs  in  PORTS  per-port write restart; write data is valid.
REQ-016 membus_addr_ack  out  PORTS  per-port address acknowledge, one-clock pulse.
REQ-017 membus_rd_rs  out  PORTS  per-port read restart, one-clock pulse.
REQ-018 membus_mb_out  out  PORTS*36  per-port read data; zero except on the granted port while rd_rs is high.
REQ-019 busy  out  1  high in every state except IDLE.

Function
REQ-020 Port p requests when rq_cyc[p] & ~fmc_select[p] & sel[p]==SEL & (rd_rq[p] | wr_rq[p]) & power.
REQ-021 Address used is the low AW bits of ma[p]; when AW<15, a port with any higher ma bit set is not requesting.
REQ-022 States: IDLE, ACK, RD, WWAIT, WR, REL.
REQ-023 IDLE: with at least one requester, grant one port, latch ma/rd_rq/wr_rq, go to ACK next clock.
REQ-024 ACK: pulse addr_ack[g] for exactly one clock, load delay counter with RD_DLY, go to RD.
REQ-025 RD: decrement counter; at zero, drive mb_out[g]=mem[a] when rd_rq was latched (else 0); pulse rd_rs[g] only when rd_rq was latched; then go to WWAIT if wr_rq was latched, else REL.
REQ-026 Read latency: rd_rs asserts exactly RD_DLY+1 clocks after addr_ack.
REQ-027 Read-modify-write: rd_rq and wr_rq both latched performs the read restart and then the write.
REQ-028 WWAIT: wait indefinitely for wr_rs[g]; on it, latch mb_in[g] and go to WR.
REQ-029 WR: write mem[a] = latched data, go to REL.
REQ-030 Write without read: mem[a] is unaffected until WR.
REQ-031 REL: wait for rq_cyc[g] low, then go to IDLE.
REQ-032 A new grant is never made in the same clock that REL exits.
REQ-033 Signals from non-granted ports are ignored while busy.
REQ-034 power low in any state returns to IDLE next clock with no pulses; mem contents are retained.
REQ-035 All pulses are registered outputs; at most one port's addr_ack or rd_rs is high in any clock.

Reset
REQ-036 On reset low, immediately: state=IDLE, addr_ack=0, rd_rs=0, mb_out=0, busy=0, counter=0, round-robin pointer=0.
REQ-037 Memory array contents are not cleared by reset.
REQ-038 Reset asserted mid-cycle aborts the cycle; a write not yet in WR is not performed.

Configuration
REQ-039 Macro COREMEM_RR_ARB_EN.
REQ-040 With COREMEM_RR_ARB_EN defined, arbitration is round-robin: search starts at (last granted + 1) mod PORTS.
REQ-041 Without COREMEM_RR_ARB_EN, arbitration is fixed priority: the lowest port number wins.

Verification
REQ-042 Scenario: mem[0o42]=0o334000_000000; port 0 read 0o42 -> addr_ack[0] pulse, then rd_rs[0] RD_DLY+1 clocks later with mb_out[0]=0o334000_000000.
REQ-043 Scenario: port 1 write 0o100 data 0o173040_000000, wr_rs after 10 clocks -> then read 0o100 returns 0o173040_000000.
REQ-044 Scenario: port 0 RMW at 0o43, initially 0 -> rd_rs returns 0; write 0o777777_777777 -> later read returns 0o777777_777777.
REQ-045 Scenario: ports 0 and 2 request continuously; with COREMEM_RR_ARB_EN grants alternate 0,2,0,2 -> without it, port 0 is granted every time.
REQ-046 Scenario: fmc_select=1, or sel!=SEL, or ma bit 21 set with AW=14 -> no addr_ack, busy stays 0.
REQ-047 Scenario: reset low during WWAIT after writing 0o5 to 0o200 earlier -> outputs go to 0 immediately; a later read of 0o200 returns 0o5.
